// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Access sizes, fault codes and FSM states.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads
// and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane, extend it, and splice store data into it.
    always_comb begin
        lane_b  = rdata_i[{off_i, 3'b000} +: 8];
        lane_h  = rdata_i[{off_i[1], 4'b0000} +: 16];
        load_o  = rdata_i;
        merge_o = wdata_i;
        if (size_i == SIZE_B) begin
            load_o  = {{24{lane_b[7] & ~unsigned_i}}, lane_b};
            merge_o = rdata_i;
            merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (size_i == SIZE_H) begin
            load_o  = {{16{lane_h[15] & ~unsigned_i}}, lane_h};
            merge_o = rdata_i;
            merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and data_memory.
// Word-aligned accesses, sub-word RMW, fault screening.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic [1:0]  fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    import lsu_pkg::*;

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] word_q, word_d;
    logic [31:0] ldata_q, ldata_d;
    logic [1:0]  size_q;
    logic [1:0]  fault_q, fault_d;
    logic        uns_q, store_q;
    logic [1:0]  acc_fault;
    logic        accept;
    logic [31:0] lane_load, lane_merge;

    assign accept = req_valid && (state_q == ST_IDLE);

    // Screen the incoming address; misalignment outranks range.
    always_comb begin
        acc_fault = FAULT_NONE;
        if ((req_size == SIZE_H && req_addr[0]) ||
            (req_size >= SIZE_W && req_addr[1:0] != 2'b00)) begin
            acc_fault = FAULT_MISALIGN;
        end else if (req_addr[31:2] >= 30'(MEM_WORDS)) begin
            acc_fault = FAULT_RANGE;
        end
    end

    lsu_lane_align u_align (
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .rdata_i    (mem_rdata),
        .wdata_i    (wdata_q),
        .load_o     (lane_load),
        .merge_o    (lane_merge)
    );

    // Sequence IDLE -> (RD) -> (WR) -> RESP; faults skip memory.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ldata_d = ldata_q;
        fault_d = fault_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    fault_d = acc_fault;
                    ldata_d = '0;
                    if (acc_fault != FAULT_NONE) begin
                        state_d = ST_RESP;
                    end else if (req_is_store && req_size >= SIZE_W) begin
                        word_d  = req_wdata;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (store_q) begin
                    word_d  = lane_merge;
                    state_d = ST_WR;
                end else begin
                    ldata_d = lane_load;
                    state_d = ST_RESP;
                end
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and working registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            ldata_q <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ldata_q <= ldata_d;
            fault_q <= fault_d;
        end
    end

    // Request fields are captured only on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SIZE_B;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            store_q <= req_is_store;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign load_data  = resp_valid ? ldata_q : '0;
    assign fault      = resp_valid ? fault_q : FAULT_NONE;
    assign mem_read   = (state_q == ST_RD);
    assign mem_write  = (state_q == ST_WR);
    assign mem_addr   = (mem_read || mem_write) ?
                        {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata  = mem_write ? word_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a
// word-memory model and per-cycle output checker.
module tb_load_store_unit;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          resp;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] ld;
        logic [1:0]  flt;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] load_data;
    logic [1:0]  fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    logic [31:0] dmem [64];
    logic [31:0] model [64];
    rec_t        q[$];

    logic [31:0] last_ld = '0;
    logic [1:0]  last_f = '0;
    logic [31:0] last_wd = '0;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .load_data    (load_data),
        .fault        (fault),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: read on falling edge, write on rising edge
    always @(negedge clk)
        if (mem_read) mem_rdata <= dmem[mem_addr[7:2]];
    always @(posedge clk)
        if (mem_write) dmem[mem_addr[7:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the expected-cycle queue
    always @(negedge clk) begin
        rec_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("mem_read", 32'(mem_read), 32'(e.rd));
            chk("mem_write", 32'(mem_write), 32'(e.wr));
            chk("resp_valid", 32'(resp_valid), 32'(e.resp));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (e.rd || e.wr) chk("mem_addr", mem_addr, e.maddr);
            if (e.wr) begin
                chk("mem_wdata", mem_wdata, e.mwd);
                last_wd = mem_wdata;
            end
            if (e.resp) begin
                chk("load_data", load_data, e.ld);
                chk("fault", 32'(fault), 32'(e.flt));
                last_ld = load_data;
                last_f  = fault;
            end
        end else begin
            chk("idle_ready", 32'(req_ready), 32'd1);
            chk("idle_rd", 32'(mem_read), 32'd0);
            chk("idle_wr", 32'(mem_write), 32'd0);
            chk("idle_resp", 32'(resp_valid), 32'd0);
            chk("idle_addr", mem_addr, 32'd0);
        end
    end

    function automatic rec_t mk(bit rd, bit wr, bit resp,
                                logic [31:0] a, logic [31:0] wd,
                                logic [31:0] ld, logic [1:0] f);
        rec_t r;
        r.rd = rd; r.wr = wr; r.resp = resp;
        r.maddr = a; r.mwd = wd; r.ld = ld; r.flt = f;
        return r;
    endfunction

    task automatic issue(input bit st, input logic [1:0] sz, input bit un,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_issue", 32'(req_ready), 32'd1);
        req_is_store = st;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // model the request from memory semantics and queue its cycles
    task automatic expect_req(input bit st, input logic [1:0] sz,
                              input bit un, input logic [31:0] a,
                              input logic [31:0] wd, input bit commit);
        int          n, sh, idx;
        bit          isw;
        logic [1:0]  f;
        logic [31:0] mask, v, wa;
        isw = (sz >= 2);
        n   = isw ? 4 : (sz == 1 ? 2 : 1);
        sh  = 8 * int'(a[1:0]);
        idx = int'(a[7:2]);
        wa  = {a[31:2], 2'b00};
        mask = (n == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * n)) - 1) << sh);
        if ((sz == 1 && a[0]) || (isw && a[1:0] != 0)) f = 2'b01;
        else if (a[31:2] >= 64) f = 2'b10;
        else f = 2'b00;
        if (f != 0) begin
            q.push_back(mk(0, 0, 1, 0, 0, 0, f));
        end else if (st) begin
            v = (model[idx] & ~mask) | ((wd << sh) & mask);
            if (!isw) q.push_back(mk(1, 0, 0, wa, 0, 0, 0));
            q.push_back(mk(0, 1, 0, wa, v, 0, 0));
            q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
            if (commit) model[idx] = v;
        end else begin
            v = (model[idx] & mask) >> sh;
            if (!un && n < 4 && v[8 * n - 1]) v = v | ~(mask >> sh);
            q.push_back(mk(1, 0, 0, wa, 0, 0, 0));
            q.push_back(mk(0, 0, 1, 0, 0, v, 0));
        end
    endtask

    task automatic do_req(input bit st, input logic [1:0] sz,
                          input bit un, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] ld_exp,
                          input logic [1:0] f_exp, input logic [31:0] wd_exp);
        issue(st, sz, un, a, wd);
        expect_req(st, sz, un, a, wd, 1'b1);
        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            chk("timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        chk("lit_ld", last_ld, ld_exp);
        chk("lit_fault", 32'(last_f), 32'(f_exp));
        if (st && f_exp == 2'b00) chk("lit_wdata", last_wd, wd_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            dmem[i]  = '0;
            model[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rd", 32'(mem_read), 32'd0);
        chk("rst_wr", 32'(mem_write), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
        do_req(0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 0);
        do_req(1, 2'b00, 0, 32'h11, 32'h5A, 0, 0, 32'hDEAD5AEF);
        do_req(0, 2'b00, 0, 32'h11, 0, 32'h0000005A, 0, 0);
        do_req(0, 2'b00, 0, 32'h13, 0, 32'hFFFFFFDE, 0, 0);
        do_req(0, 2'b00, 1, 32'h13, 0, 32'h000000DE, 0, 0);

        issue(1, 2'b00, 0, 32'h10, 32'hFF);
        expect_req(1, 2'b00, 0, 32'h10, 32'hFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", 32'(mem_write), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_req(0, 2'b10, 0, 32'h10, 0, 32'hDEAD5AEF, 0, 0);

        do_req(1, 2'b01, 0, 32'h12, 32'h8001, 0, 0, 32'h80015AEF);
        do_req(0, 2'b01, 0, 32'h12, 0, 32'hFFFF8001, 0, 0);
        do_req(0, 2'b01, 1, 32'h12, 0, 32'h00008001, 0, 0);
        do_req(0, 2'b11, 0, 32'h10, 0, 32'h80015AEF, 0, 0);

        do_req(0, 2'b10, 0, 32'h12, 0, 0, 2'b01, 0);
        do_req(1, 2'b10, 0, 32'h100, 32'h1234, 0, 2'b10, 0);
        do_req(0, 2'b01, 0, 32'h101, 0, 0, 2'b01, 0);
        do_req(0, 2'b00, 0, 32'hFC, 0, 0, 2'b00, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the EX/MEM pipeline register and data_memory in the pipelined datapath. It turns lw/lh/lhu/lb/lbu/sw/sh/sb requests into word-aligned accesses on data_memory.
- Sub-word stores run as read-modify-write.
- Loads are extracted and sign- or zero-extended.
- Misaligned and out-of-range addresses are faulted without touching memory.
- A valid/ready handshake lets the hazard unit stall the pipeline while an access is in flight.

Parameters:
MEM_WORDS, 64, number of 32-bit words in data_memory; word index = addr[31:2]; valid indices are 0..MEM_WORDS-1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
req_valid  input  1  request present; held stable by upstream until accepted.
req_ready  output  1  high only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
req_is_store  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-justified.
resp_valid  output  1  one-cycle pulse when the operation completes.
load_data  output  32  extended load result; valid with resp_valid; 0 for stores and faults.
fault  output  2  00 none, 01 misaligned, 10 out of range; valid with resp_valid.
mem_read  output  1  to data_memory MemRead.
mem_write  output  1  to data_memory MemWrite.
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}; 0 when idle.
mem_wdata  output  32  full word to write.
mem_rdata  input  32  data_memory read_data.

Behaviour:
- Reset (async, rst_n low):
  - State returns to IDLE.
  - resp_valid, load_data, fault, mem_read, mem_write, mem_addr and mem_wdata are all 0.
  - req_ready = 1.
  - Reset mid-operation abandons the operation: mem_write drops immediately and no partial write occurs.
- On accept, the unit latches addr, size, unsigned, wdata and is_store. It then checks the address:
  - Misaligned: size=01 with addr[0]=1, or size=word with addr[1:0]!=0.
  - Out of range: addr[31:2] >= MEM_WORDS.
  - Misaligned has priority over out of range.
- FSM states: IDLE, RD, WR, RESP.
- IDLE -> RESP on a faulted request; no memory access is made.
- IDLE -> WR on a word store, with merged word = wdata.
- IDLE -> RD on a load or a sub-word store.
- RD:
  - mem_read=1 and mem_addr is driven.
  - mem_rdata is sampled on the rising edge that ends RD (data_memory updates read_data on the falling edge).
  - A load goes to RESP with extracted data.
  - A sub-word store merges its data into the sampled word and goes to WR.
- WR: mem_write=1, mem_addr and mem_wdata are driven; data_memory commits on the rising edge ending WR. Next state is RESP.
- RESP: resp_valid=1, with load_data and fault valid. Next state is IDLE. The next request can be accepted on the edge after RESP.
- mem_* outputs are decoded from registered state and latched fields only; there is no combinational path from req_* to mem_*.
- Byte lanes are little-endian:
  - A byte at addr[1:0]=k occupies bits [8k+7:8k].
  - A halfword at addr[1]=h occupies bits [16h+15:16h].
  - A merge replaces only the target lane; the other lanes keep the sampled word.
- Extension: lb sign-extends bit 7 and lh bit 15; lbu and lhu zero-extend. A word load is returned unchanged.
- Latency from the accept edge T:
  - Word load: RD at T+1, RESP at T+2.
  - Word store: WR at T+1, RESP at T+2.
  - Sub-word store: RD at T+1, WR at T+2, RESP at T+3.
  - Fault: RESP at T+1.
  - Sub-word load: same as word load.
- req_valid while the unit is busy is ignored: req_ready=0 and the request is not latched.

Decomposition:
- Shared package lsu_pkg holds:
  - The size encoding: SIZE_B, SIZE_H, SIZE_W.
  - Fault codes: FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE.
  - The FSM state enum.
- One natural combinational sub-module, lsu_lane_align, provides lane extract/extend (for loads) and lane merge (for stores) given addr[1:0], size and unsigned.

Test Plan:
- Reset and idle check -> hold rst_n low, then release -> all outputs 0 and req_ready=1. No mem_read or mem_write in the 5 idle cycles that follow.
- Word store and load:
  - sw 0xDEADBEEF to 0x10 -> mem_write high only at T+1, mem_addr=0x10, resp_valid at T+2.
  - lw 0x10 -> mem_read at T+1, load_data=0xDEADBEEF at T+2.
- Byte read-modify-write and byte loads:
  - sb 0x5A to 0x11 -> RD at T+1, WR at T+2 with mem_wdata=0xDEAD5AEF.
  - lb 0x11 -> 0x0000005A.
  - lb 0x13 -> 0xFFFFFFDE.
  - lbu 0x13 -> 0x000000DE.
- Halfword store and loads:
  - sh 0x8001 to 0x12 -> word 0x80015AEF.
  - lh 0x12 -> 0xFFFF8001.
  - lhu 0x12 -> 0x00008001.
- Faults:
  - lw 0x12 -> resp_valid at T+1, fault=01, no mem_read or mem_write.
  - sw 0x100 -> fault=10.
  - lh 0x101 -> fault=01 (misaligned wins).
- Reset mid-operation -> sb 0xFF to 0x10, then assert rst_n low during WR -> mem_write falls asynchronously and word 0x10 still reads 0xDEAD5AEF. After release, a new request is accepted immediately.
